// File: rtl/bcd_pkg.sv
// Shared BCD definitions: widths, decoded-word struct and the BCD-to-one-hot map
// used by the decoder and by the dec2bcd benches.
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam int DEC_W = 10;

  typedef struct packed {
    logic             err;
    logic [DEC_W-1:0] dec;
  } dec_word_t;

  // Digit 0 sits on bit0, digits 1..9 count down from bit9 (dec2bcd numbering).
  function automatic dec_word_t bcd_to_onehot(input logic [BCD_W-1:0] code);
    dec_word_t w;
    w.err = 1'b0;
    w.dec = '0;
    case (code)
      4'd0:    w.dec = 10'b00_0000_0001;
      4'd1:    w.dec = 10'b10_0000_0000;
      4'd2:    w.dec = 10'b01_0000_0000;
      4'd3:    w.dec = 10'b00_1000_0000;
      4'd4:    w.dec = 10'b00_0100_0000;
      4'd5:    w.dec = 10'b00_0010_0000;
      4'd6:    w.dec = 10'b00_0001_0000;
      4'd7:    w.dec = 10'b00_0000_1000;
      4'd8:    w.dec = 10'b00_0000_0100;
      4'd9:    w.dec = 10'b00_0000_0010;
      default: w.err = 1'b1;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/bcd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/level all derive from the pointers.
module bcd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Same index with differing wrap bit means the writer lapped the reader.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];
endmodule

// File: rtl/bcd2dec_buf.sv
// Buffered BCD-to-one-hot decoder: FIFO in front of a registered output stage,
// with a saturating count of invalid codes accepted.
module bcd2dec_buf
  import bcd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [BCD_W-1:0]       in_bcd,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DEC_W-1:0]       out_dec,
  output logic                   out_err,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [ERR_CNT_W-1:0]   err_count
);
  logic             push, load, full, empty;
  logic [BCD_W-1:0] head;
  dec_word_t        head_w;

  // No pass-through: a full FIFO refuses input even on a popping cycle.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign load     = !empty && (!out_valid || out_ready);
  assign head_w   = bcd_to_onehot(head);

  bcd_fifo #(.WIDTH(BCD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_bcd),
    .pop   (load),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_dec   <= '0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_dec   <= head_w.dec;
      out_err   <= head_w.err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (push && (in_bcd >= 4'd10) && (err_count != '1))
      err_count <= err_count + ERR_CNT_W'(1);
  end
endmodule

// File: tb/tb_bcd2dec_buf.sv
// Directed bench for bcd2dec_buf (DEPTH=4, ERR_CNT_W=2) with hand-written one-hot expectations.
module tb_bcd2dec_buf;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [3:0] in_bcd;
  logic       in_ready, out_valid, out_err;
  logic [9:0] out_dec;
  logic [2:0] level;
  logic [1:0] err_count;

  int nvec = 0;
  int nerr = 0;

  // Expected one-hot per digit 0..9.
  logic [9:0] oh [10] = '{10'h001, 10'h200, 10'h100, 10'h080, 10'h040,
                          10'h020, 10'h010, 10'h008, 10'h004, 10'h002};

  bcd2dec_buf #(.DEPTH(4), .ERR_CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bcd    (in_bcd),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_dec   (out_dec),
    .out_err   (out_err),
    .out_ready (out_ready),
    .level     (level),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pi, qi;
    logic [3:0] d6 [6] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    rst_n = 1'b0; in_valid = 1'b0; in_bcd = 4'd0; out_ready = 1'b0;
    #12 rst_n = 1'b1;
    step();
    chk("rst_level",  32'(level),     32'd0);
    chk("rst_ready",  32'(in_ready),  32'd1);
    chk("rst_valid",  32'(out_valid), 32'd0);
    chk("rst_dec",    32'(out_dec),   32'd0);
    chk("rst_err",    32'(out_err),   32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);

    // 0,1,9 streamed with consumer ready
    out_ready = 1'b1; in_valid = 1'b1; in_bcd = 4'd0;
    step(); in_bcd = 4'd1;
    step(); chk("d0_valid", 32'(out_valid), 32'd1); chk("d0_dec", 32'(out_dec), 32'h001);
    in_bcd = 4'd9;
    step(); chk("d1_dec", 32'(out_dec), 32'h200);
    in_valid = 1'b0;
    step(); chk("d9_dec", 32'(out_dec), 32'h002); chk("d9_err", 32'(out_err), 32'd0);
    step(); chk("idle_valid", 32'(out_valid), 32'd0); chk("idle_hold", 32'(out_dec), 32'h002);

    // invalid codes and counter saturation
    in_valid = 1'b1; in_bcd = 4'hA;
    step(); in_bcd = 4'hF;
    step(); chk("A_dec", 32'(out_dec), 32'd0); chk("A_err", 32'(out_err), 32'd1);
    chk("errcnt2", 32'(err_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(); chk("errcnt_sat", 32'(err_count), 32'd3);
    end
    chk("F_err", 32'(out_err), 32'd1);
    in_valid = 1'b0;
    step(); step(); step();
    chk("drain_level", 32'(level), 32'd0); chk("drain_valid", 32'(out_valid), 32'd0);

    // fill with consumer stalled: 5 accepted, 6th held
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_bcd = d6[i];
      chk("fill_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_bcd = d6[5];
    chk("full_level", 32'(level), 32'd4); chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_dec", 32'(out_dec), 32'h080);
    step(); step();
    chk("stall_level", 32'(level), 32'd4); chk("stall_dec", 32'(out_dec), 32'h080);
    chk("stall_valid", 32'(out_valid), 32'd1);

    // release: pop without push on the full cycle
    out_ready = 1'b1;
    step(); chk("rel_dec4", 32'(out_dec), 32'h040); chk("rel_level", 32'(level), 32'd3);
    chk("rel_ready", 32'(in_ready), 32'd1);
    step(); chk("rel_dec5", 32'(out_dec), 32'h020); chk("rel_level_pp", 32'(level), 32'd3);
    in_valid = 1'b0;
    step(); chk("rel_dec6", 32'(out_dec), 32'h010);
    step(); chk("rel_dec7", 32'(out_dec), 32'h008);
    step(); chk("rel_dec8", 32'(out_dec), 32'h004); chk("rel_empty", 32'(level), 32'd0);
    step(); chk("rel_done", 32'(out_valid), 32'd0);

    // steady push+pop at level 2, digits k%10
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_bcd = 4'(k % 10);
      step();
    end
    chk("ss_prelevel", 32'(level), 32'd2); chk("ss_head", 32'(out_dec), 32'(oh[0]));
    out_ready = 1'b1; pi = 3; qi = 1;
    for (int c = 0; c < 20; c++) begin
      in_bcd = 4'(pi % 10);
      step();
      pi++;
      chk("ss_level", 32'(level), 32'd2);
      chk("ss_dec", 32'(out_dec), 32'(oh[qi % 10]));
      qi++;
    end

    // build level 3, then reset mid-stream
    out_ready = 1'b0; in_bcd = 4'd5;
    step(); chk("pre_rst_level", 32'(level), 32'd3);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid",  32'(out_valid), 32'd0);
    chk("mrst_level",  32'(level),     32'd0);
    chk("mrst_ready",  32'(in_ready),  32'd1);
    chk("mrst_errcnt", 32'(err_count), 32'd0);
    chk("mrst_dec",    32'(out_dec),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    step(); step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_level", 32'(level),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
